// File: rtl/pci_pkg.sv
// Shared PCI definitions: command codes, completion status, and master state encoding.
package pci_pkg;

  localparam logic [3:0] CMD_SPECIAL = 4'b0001;
  localparam logic [3:0] CMD_IO_RD   = 4'b0010;
  localparam logic [3:0] CMD_IO_WR   = 4'b0011;
  localparam logic [3:0] CMD_MEM_RD  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR  = 4'b0111;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_MABORT = 2'b01,
    ST_DISC   = 2'b10
  } status_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    END  = 3'd3,
    TURN = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  be;
  } req_t;

  // A zero length still moves one word; long bursts are cut to the burst limit.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (len == 4'd0) return 4'd1;
    if (int'(len) > max_len) return 4'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// PCI bus wires; the two tri-state groups are resolved here from per-side drive enables.
interface pci_initiator_if;
  wire  [31:0] Address_Data;
  wire  [3:0]  C_BE;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [3:0]  cbe_out;
  logic        cbe_oe;
  logic [31:0] tgt_ad;
  logic        tgt_oe;
  logic        NFRAME;
  logic        NIRED;
  logic        NTRED;
  logic        NDEVSEL;
  logic        stop;

  assign Address_Data = ad_oe ? ad_out : (tgt_oe ? tgt_ad : 'z);
  assign C_BE         = cbe_oe ? cbe_out : 'z;

  modport master (
    output ad_out, ad_oe, cbe_out, cbe_oe, NFRAME, NIRED,
    input  Address_Data, NTRED, NDEVSEL, stop
  );

  modport slave (
    input  Address_Data, C_BE, NFRAME, NIRED,
    output tgt_ad, tgt_oe, NTRED, NDEVSEL, stop
  );
endinterface

// File: rtl/pci_initiator.sv
// PCI bus master: one request -> address phase plus 1..MAX_BURST data phases,
// with wait states, target disconnect, master abort and special cycles.
module pci_initiator
  import pci_pkg::*;
#(
  parameter int MAX_BURST      = 8,
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int SPECIAL_HOLD   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [3:0]  req_be,
  input  logic [31:0] wr_data,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  status,
  output logic [3:0]  xfer_count,
  pci_initiator_if.master bus
);

  state_t      state, nxt;
  req_t        rq;
  logic [3:0]  remaining;
  logic [7:0]  tmr;
  logic        dev_seen;
  logic [31:0] ad_q;
  logic        is_wr, special, last;
  logic        xfer_ok, stop_hit, abort_hit, hold_done;

  assign is_wr   = rq.cmd[0];
  assign special = (rq.cmd == CMD_SPECIAL);
  assign last    = (remaining == 4'd1);

  // NIRED is low throughout DATA, so a phase completes on target ready + select alone.
  assign xfer_ok   = (state == DATA) && !special && !bus.NTRED && !bus.NDEVSEL;
  assign stop_hit  = (state == DATA) && !special && !bus.stop;
  // tmr counts clocks since ADDR; abort fires so that END lands DEVSEL_TIMEOUT clocks after ADDR.
  assign abort_hit = (state == DATA) && !special && !dev_seen && bus.NDEVSEL &&
                     (tmr == 8'(DEVSEL_TIMEOUT - 1));
  assign hold_done = (state == DATA) && special && (tmr == 8'(SPECIAL_HOLD));

  assign req_ready = (state == IDLE) && reset;
  assign done      = (state == TURN);
  assign wr_pop    = (xfer_ok && is_wr) || hold_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt         = state;
    bus.ad_out  = '0;
    bus.ad_oe   = 1'b0;
    bus.cbe_out = '0;
    bus.cbe_oe  = 1'b0;
    bus.NFRAME  = 1'b1;
    bus.NIRED   = 1'b1;
    unique case (state)
      IDLE: if (req_valid) nxt = ADDR;
      ADDR: begin
        bus.ad_out  = rq.addr;
        bus.ad_oe   = 1'b1;
        bus.cbe_out = rq.cmd;
        bus.cbe_oe  = 1'b1;
        bus.NFRAME  = 1'b0;
        nxt         = DATA;
      end
      DATA: begin
        bus.ad_out  = wr_data;
        bus.ad_oe   = is_wr;
        bus.cbe_out = rq.be;
        bus.cbe_oe  = 1'b1;
        bus.NFRAME  = special || last;
        bus.NIRED   = 1'b0;
        if (hold_done)                  nxt = TURN;
        else if (stop_hit || abort_hit) nxt = END;
        else if (xfer_ok && last)       nxt = TURN;
      end
      END: begin
        bus.ad_out  = ad_q;
        bus.ad_oe   = is_wr;
        bus.cbe_out = rq.be;
        bus.cbe_oe  = 1'b1;
        bus.NIRED   = 1'b0;
        nxt         = TURN;
      end
      TURN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq         <= '0;
      remaining  <= '0;
      tmr        <= '0;
      dev_seen   <= 1'b0;
      ad_q       <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      status     <= ST_OK;
      xfer_count <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        rq         <= '{cmd: req_cmd, addr: req_addr, be: req_be};
        remaining  <= clamp_len(req_len, MAX_BURST);
        tmr        <= '0;
        dev_seen   <= 1'b0;
        status     <= ST_OK;
        xfer_count <= '0;
      end
      if ((state == ADDR || state == DATA) && tmr != '1) tmr <= tmr + 8'd1;
      if (state == DATA) begin
        ad_q <= wr_data;
        if (!bus.NDEVSEL) dev_seen <= 1'b1;
      end
      if (xfer_ok) begin
        xfer_count <= xfer_count + 4'd1;
        remaining  <= remaining - 4'd1;
        if (!is_wr) begin
          rd_data  <= bus.Address_Data;
          rd_valid <= 1'b1;
        end
      end
      if (hold_done) xfer_count <= 4'd1;
      if (abort_hit) status <= ST_MABORT;
      // A stop that lands on the final completing phase is a clean finish.
      if (stop_hit)  status <= (xfer_ok && last) ? ST_OK : ST_DISC;
    end
  end

endmodule
